// File: rtl/rvcpu_pkg.sv
// rvcpu_pkg: shared widths, encodings and pipeline-register bundles
// for the pipelined RV64I core slice.
package rvcpu_pkg;
  localparam int          REG_BUS      = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [1:0] IT_NONE = 2'd0;
  localparam logic [1:0] IT_I    = 2'd1;
  localparam logic [1:0] IT_R    = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [63:0] pc;
  } ifid_t;

  typedef struct packed {
    logic               valid;
    logic [1:0]         inst_type;
    logic [2:0]         inst_opcode;
    logic [REG_BUS-1:0] op1;
    logic [REG_BUS-1:0] op2;
    logic               rd_w_ena;
    logic [4:0]         rd_w_addr;
  } idex_t;

  typedef struct packed {
    logic               valid;
    logic               rd_w_ena;
    logic [4:0]         rd_w_addr;
    logic [REG_BUS-1:0] rd_data;
  } exwb_t;
endpackage

// File: rtl/exe_stage.sv
// exe_stage: single-cycle ALU; undecoded slots produce zero.
module exe_stage
  import rvcpu_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic [1:0]      inst_type_i,
  input  logic [2:0]      inst_opcode_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic [XLEN-1:0] rd_data_o
);
  logic [XLEN-1:0] res;

  always_comb begin
    res = '0;
    unique case (inst_opcode_i)
      ALU_ADD: res = op1_i + op2_i;
      ALU_SUB: res = op1_i - op2_i;
      ALU_XOR: res = op1_i ^ op2_i;
      ALU_OR:  res = op1_i | op2_i;
      ALU_AND: res = op1_i & op2_i;
      default: res = '0;
    endcase
  end

  assign rd_data_o = (inst_type_i == IT_NONE) ? '0 : res;
endmodule

// File: rtl/id_stage.sv
// id_stage: decodes the OP-IMM / OP ALU subset and forms op1/op2
// from the (already forwarded) register data.
module id_stage
  import rvcpu_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic            rs1_ena_o,
  output logic            rs2_ena_o,
  output logic [1:0]      inst_type_o,
  output logic [2:0]      inst_opcode_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic            rd_w_ena_o,
  output logic [4:0]      rd_w_addr_o
);
  logic [6:0]      opc;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic            f3_ok;
  logic            is_i;
  logic            is_r;
  logic [XLEN-1:0] imm;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign imm   = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign f3_ok = (f3 == 3'b000) | (f3 == 3'b100) |
                 (f3 == 3'b110) | (f3 == 3'b111);
  assign is_i  = (opc == OPC_OPIMM) & f3_ok;
  assign is_r  = (opc == OPC_OP) & f3_ok &
                 ((f7 == 7'h00) | ((f7 == 7'h20) & (f3 == 3'b000)));

  always_comb begin
    inst_type_o = IT_NONE;
    unique case (1'b1)
      is_r:    inst_type_o = IT_R;
      is_i:    inst_type_o = IT_I;
      default: inst_type_o = IT_NONE;
    endcase
    inst_opcode_o = ALU_ADD;
    unique case (f3)
      3'b100:  inst_opcode_o = ALU_XOR;
      3'b110:  inst_opcode_o = ALU_OR;
      3'b111:  inst_opcode_o = ALU_AND;
      default: inst_opcode_o = (is_r & f7[5]) ? ALU_SUB : ALU_ADD;
    endcase
  end

  assign rs1_addr_o  = inst_i[19:15];
  assign rs2_addr_o  = inst_i[24:20];
  assign rs1_ena_o   = is_i | is_r;
  assign rs2_ena_o   = is_r;
  assign op1_o       = rs1_data_i;
  assign op2_o       = is_r ? rs2_data_i : imm;
  assign rd_w_ena_o  = is_i | is_r;
  assign rd_w_addr_o = inst_i[11:7];
endmodule

// File: rtl/regfile.sv
// regfile: 32 x XLEN integer registers, two read ports, one write port.
// x0 is never written, so it always reads zero.
module regfile
  import rvcpu_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      w_addr_i,
  input  logic [XLEN-1:0] w_data_i,
  input  logic            w_ena_i,
  input  logic [4:0]      r_addr1_i,
  input  logic            r_ena1_i,
  output logic [XLEN-1:0] r_data1_o,
  input  logic [4:0]      r_addr2_i,
  input  logic            r_ena2_i,
  output logic [XLEN-1:0] r_data2_o
);
  logic [XLEN-1:0] regs_q [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (w_ena_i && (w_addr_i != 5'd0)) begin
      regs_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data1_o = r_ena1_i ? regs_q[r_addr1_i] : '0;
  assign r_data2_o = r_ena2_i ? regs_q[r_addr2_i] : '0;
endmodule

// File: rtl/rvcpu_fwd_unit.sv
// rvcpu_fwd_unit: picks each source operand from EX, then WB,
// then the regfile; the nearest producer is the newest value.
module rvcpu_fwd_unit #(
  parameter int XLEN  = 64,
  parameter bit WB_EN = 1'b1
) (
  input  logic            ex_valid_i,
  input  logic            ex_we_i,
  input  logic [4:0]      ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            wb_valid_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [XLEN-1:0] rf1_data_i,
  input  logic [XLEN-1:0] rf2_data_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o
);
  logic ex_hit1;
  logic ex_hit2;
  logic wb_hit1;
  logic wb_hit2;

  function automatic logic hit(input logic v, input logic we,
                               input logic [4:0] rd,
                               input logic [4:0] rs);
    return v & we & (rd != 5'd0) & (rd == rs);
  endfunction

  assign ex_hit1 = hit(ex_valid_i, ex_we_i, ex_rd_i, rs1_addr_i);
  assign ex_hit2 = hit(ex_valid_i, ex_we_i, ex_rd_i, rs2_addr_i);
  assign wb_hit1 = WB_EN & hit(wb_valid_i, wb_we_i, wb_rd_i, rs1_addr_i);
  assign wb_hit2 = WB_EN & hit(wb_valid_i, wb_we_i, wb_rd_i, rs2_addr_i);

  assign rs1_data_o = ex_hit1 ? ex_data_i :
                      wb_hit1 ? wb_data_i : rf1_data_i;
  assign rs2_data_o = ex_hit2 ? ex_data_i :
                      wb_hit2 ? wb_data_i : rf2_data_i;
endmodule

// File: rtl/rvcpu_pipe.sv
// rvcpu_pipe: 3/4-stage RV64I ALU pipeline with a valid-only fetch
// handshake, full forwarding and a retired-instruction counter.
module rvcpu_pipe
  import rvcpu_pkg::*;
#(
  parameter int          XLEN     = REG_BUS,
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter bit          WB_REG   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic [63:0] inst_addr,
  output logic        inst_ena,
  output logic [63:0] instret
);
  logic [63:0]     pc_q, pc_d;
  logic            ena_q;
  logic            hs;
  logic [63:0]     instret_q, instret_d;
  ifid_t           ifid_q, ifid_d;
  idex_t           idex_q, idex_d;
  exwb_t           exwb_q, exwb_d;
  logic [4:0]      rs1_addr, rs2_addr, id_rd;
  logic            rs1_ena, rs2_ena, id_we;
  logic [1:0]      id_type;
  logic [2:0]      id_op;
  logic [XLEN-1:0] rf1, rf2, rs1_data, rs2_data;
  logic [XLEN-1:0] op1, op2, ex_data;
  logic            wr_valid, wr_we;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            unused_pc;

  assign hs     = ena_q & inst_valid;
  assign pc_d   = hs ? pc_q + 64'd4 : pc_q;
  assign ifid_d = '{valid: hs, inst: inst, pc: pc_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      ena_q     <= 1'b0;
      ifid_q    <= '0;
      idex_q    <= '0;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ena_q     <= 1'b1;
      ifid_q    <= ifid_d;
      idex_q    <= idex_d;
      instret_q <= instret_d;
    end
  end

  id_stage #(.XLEN(XLEN)) u_id (
    .inst_i        (ifid_q.inst),
    .rs1_data_i    (rs1_data),
    .rs2_data_i    (rs2_data),
    .rs1_addr_o    (rs1_addr),
    .rs2_addr_o    (rs2_addr),
    .rs1_ena_o     (rs1_ena),
    .rs2_ena_o     (rs2_ena),
    .inst_type_o   (id_type),
    .inst_opcode_o (id_op),
    .op1_o         (op1),
    .op2_o         (op2),
    .rd_w_ena_o    (id_we),
    .rd_w_addr_o   (id_rd)
  );

  regfile #(.XLEN(XLEN)) u_rf (
    .clk_i     (clk),
    .rst_i     (~rst),
    .w_addr_i  (wr_addr),
    .w_data_i  (wr_data),
    .w_ena_i   (wr_valid & wr_we),
    .r_addr1_i (rs1_addr),
    .r_ena1_i  (rs1_ena),
    .r_data1_o (rf1),
    .r_addr2_i (rs2_addr),
    .r_ena2_i  (rs2_ena),
    .r_data2_o (rf2)
  );

  rvcpu_fwd_unit #(.XLEN(XLEN), .WB_EN(WB_REG)) u_fwd (
    .ex_valid_i (idex_q.valid),
    .ex_we_i    (idex_q.rd_w_ena),
    .ex_rd_i    (idex_q.rd_w_addr),
    .ex_data_i  (ex_data),
    .wb_valid_i (exwb_q.valid),
    .wb_we_i    (exwb_q.rd_w_ena),
    .wb_rd_i    (exwb_q.rd_w_addr),
    .wb_data_i  (exwb_q.rd_data),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rf1_data_i (rf1),
    .rf2_data_i (rf2),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data)
  );

  always_comb begin
    idex_d             = '0;
    idex_d.valid       = ifid_q.valid;
    idex_d.inst_type   = id_type;
    idex_d.inst_opcode = id_op;
    idex_d.op1         = op1;
    idex_d.op2         = op2;
    idex_d.rd_w_ena    = ifid_q.valid & id_we;
    idex_d.rd_w_addr   = id_rd;
  end

  exe_stage #(.XLEN(XLEN)) u_exe (
    .inst_type_i   (idex_q.inst_type),
    .inst_opcode_i (idex_q.inst_opcode),
    .op1_i         (idex_q.op1),
    .op2_i         (idex_q.op2),
    .rd_data_o     (ex_data)
  );

  assign exwb_d = '{valid:     idex_q.valid,
                    rd_w_ena:  idex_q.rd_w_ena,
                    rd_w_addr: idex_q.rd_w_addr,
                    rd_data:   ex_data};

  if (WB_REG) begin : g_wb
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) exwb_q <= '0;
      else      exwb_q <= exwb_d;
    end
    assign wr_valid = exwb_q.valid;
    assign wr_we    = exwb_q.rd_w_ena;
    assign wr_addr  = exwb_q.rd_w_addr;
    assign wr_data  = exwb_q.rd_data;
  end else begin : g_nowb
    assign exwb_q   = '0;
    assign wr_valid = exwb_d.valid;
    assign wr_we    = exwb_d.rd_w_ena;
    assign wr_addr  = exwb_d.rd_w_addr;
    assign wr_data  = exwb_d.rd_data;
  end

  // Every valid slot at the write-back point retires, even rd-less ones.
  assign instret_d = instret_q + {63'd0, wr_valid};

  assign inst_addr = pc_q;
  assign inst_ena  = ena_q;
  assign instret   = instret_q;
  assign unused_pc = ^ifid_q.pc;
endmodule

// File: tb/tb_rvcpu_pipe.sv
// tb_rvcpu_pipe: random and directed ALU streams on a 4-stage and a
// 3-stage core; an ISA-level model feeds a per-core retire scoreboard.
module tb_rvcpu_pipe;
  localparam logic [63:0] PC1 = 64'h8000_0000;
  localparam logic [63:0] PC0 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] addr1, ret1, addr0, ret0;
  logic        ena1, ena0;

  rvcpu_pipe dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .inst_addr(addr1), .inst_ena(ena1), .instret(ret1)
  );

  rvcpu_pipe #(.RESET_PC(PC0), .WB_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .inst_addr(addr0), .inst_ena(ena0), .instret(ret0)
  );

  typedef struct {
    int          rd;
    logic [63:0] val;
    int          edge_n;
    logic [63:0] cnt;
  } exp_t;

  exp_t        q1[$];
  exp_t        q0[$];
  logic [63:0] mreg [32];
  logic [63:0] pc1, pc0, nret, prev1, prev0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input int k, input int rd,
                                      input int rs1, input int rs2,
                                      input logic [11:0] imm);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] d, s1, s2;
    d  = rd[4:0];
    s1 = rs1[4:0];
    s2 = rs2[4:0];
    case (k)
      0, 4, 5: f3 = 3'b000;
      1, 6:    f3 = 3'b100;
      2, 7:    f3 = 3'b110;
      default: f3 = 3'b111;
    endcase
    f7 = (k == 5) ? 7'h20 : 7'h00;
    if (k < 4) return {imm, s1, f3, d, 7'h13};
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction

  function automatic logic [63:0] ref_op(input int k, input logic [63:0] a,
                                         input logic [63:0] b);
    case (k)
      0, 4:    return a + b;
      5:       return a - b;
      1, 6:    return a ^ b;
      2, 7:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic retire(input int w, input logic [63:0] ret);
    exp_t        e;
    bit          have;
    logic [63:0] rv;
    have = 1'b0;
    if (w == 1) begin
      if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    end else begin
      if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    end
    if (!have) begin
      n_chk++;
      n_fail++;
      $display("FAIL spurious_retire wb%0d: instret=%0d, none expected",
               w, ret);
    end else begin
      rv = (w == 1) ? dut.u_rf.regs_q[e.rd] : dut0.u_rf.regs_q[e.rd];
      chk($sformatf("retire_cycle_wb%0d", w), 64'(cyc), 64'(e.edge_n));
      chk($sformatf("instret_wb%0d", w), ret, e.cnt);
      chk($sformatf("x%0d_wb%0d", e.rd, w), rv, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev1 = '0;
      prev0 = '0;
    end else begin
      if (ret1 != prev1) begin
        chk("instret_step_wb1", ret1, prev1 + 64'd1);
        retire(1, ret1);
        prev1 = ret1;
      end
      if (ret0 != prev0) begin
        chk("instret_step_wb0", ret0, prev0 + 64'd1);
        retire(0, ret0);
        prev0 = ret0;
      end
    end
  end

  task automatic issue(input int k, input int rd, input int rs1,
                       input int rs2, input logic [11:0] imm,
                       input int waits);
    logic [63:0] a, b, res;
    exp_t        e;
    repeat (waits) begin
      chk("inst_addr_wait_wb1", addr1, pc1);
      chk("inst_addr_wait_wb0", addr0, pc0);
      inst       = $urandom;
      inst_valid = 1'b0;
      @(negedge clk);
    end
    chk("inst_addr_wb1", addr1, pc1);
    chk("inst_addr_wb0", addr0, pc0);
    chk("inst_ena_wb1", {63'd0, ena1}, 64'd1);
    inst       = enc(k, rd, rs1, rs2, imm);
    inst_valid = 1'b1;
    a   = mreg[rs1];
    b   = (k < 4) ? {{52{imm[11]}}, imm} : mreg[rs2];
    res = ref_op(k, a, b);
    if (rd != 0) mreg[rd] = res;
    nret     = nret + 64'd1;
    e.rd     = rd;
    e.val    = (rd != 0) ? res : 64'd0;
    e.cnt    = nret;
    e.edge_n = cyc + 4;
    q1.push_back(e);
    e.edge_n = cyc + 3;
    q0.push_back(e);
    pc1 = pc1 + 64'd4;
    pc0 = pc0 + 64'd4;
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b0;
    inst_valid = 1'b1;
    inst       = enc(0, 5, 0, 0, 12'h123);
    q1.delete();
    q0.delete();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    pc1  = PC1;
    pc0  = PC0;
    nret = '0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_ena_wb1", {63'd0, ena1}, 64'd0);
      chk("rst_ena_wb0", {63'd0, ena0}, 64'd0);
      chk("rst_instret_wb1", ret1, nret);
      chk("rst_instret_wb0", ret0, nret);
      chk("rst_addr_wb1", addr1, pc1);
      chk("rst_addr_wb0", addr0, pc0);
    end
    inst_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    chk("post_rst_ena_wb1", {63'd0, ena1}, 64'd1);
    chk("post_rst_ena_wb0", {63'd0, ena0}, 64'd1);
    chk("post_rst_instret_wb1", ret1, nret);
    chk("post_rst_addr_wb1", addr1, pc1);
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b0;
    inst_valid = 1'b0;
    inst       = '0;
    do_reset(3);

    issue(0, 1, 0, 0, 12'd5, 0);
    issue(0, 2, 1, 0, 12'd3, 0);
    issue(4, 3, 2, 1, 12'd0, 0);
    repeat (2) @(negedge clk);
    chk("raw_instret_wb0", ret0, nret);
    chk("raw_instret_early_wb1", ret1, nret - 64'd1);
    @(negedge clk);
    chk("raw_instret_wb1", ret1, nret);
    chk("raw_x3_wb1", dut.u_rf.regs_q[3], mreg[3]);
    chk("raw_x3_wb0", dut0.u_rf.regs_q[3], mreg[3]);

    do_reset(2);
    chk("pc_wrap_start", addr0, PC0);
    issue(0, 1, 0, 0, 12'd5, 2);
    chk("pc_wrap", addr0, pc0);
    issue(0, 2, 1, 0, 12'd3, 2);
    issue(4, 3, 2, 1, 12'd0, 2);
    drain();
    chk("wait_x3_wb1", dut.u_rf.regs_q[3], mreg[3]);

    issue(0, 0, 0, 0, 12'd7, 0);
    issue(0, 4, 0, 0, 12'd1, 0);
    drain();
    chk("x0_stays_zero", dut.u_rf.regs_q[0], 64'd0);
    chk("x4_from_x0", dut0.u_rf.regs_q[4], mreg[4]);

    issue(0, 6, 0, 0, 12'h7ff, 0);
    issue(5, 7, 6, 4, 12'd0, 0);
    do_reset(2);
    drain();
    chk("midrst_instret_wb1", ret1, 64'd0);
    chk("midrst_x6_wb1", dut.u_rf.regs_q[6], mreg[6]);
    chk("midrst_addr_wb1", addr1, PC1);

    for (int n = 0; n < 300; n++) begin
      int k, rd, s1, s2, w;
      k  = int'($urandom_range(0, 8));
      rd = int'($urandom_range(0, 7));
      s1 = int'($urandom_range(0, 7));
      s2 = int'($urandom_range(0, 7));
      w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      issue(k, rd, s1, s2, 12'($urandom), w);
    end
    drain();
    chk("drain_q_wb1", 64'(q1.size()), 64'd0);
    chk("drain_q_wb0", 64'(q0.size()), 64'd0);
    chk("final_instret_wb1", ret1, nret);
    chk("final_instret_wb0", ret0, nret);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
